// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with circular byte FIFO
//
// Accepts bytes over a valid/ready port into a 2**FIFO_DEPTH_LOG2 entry FIFO
// and serialises them LSB first as 8N1 frames on a registered tx line.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high; aborts any frame and flushes the FIFO
//   in_data    byte to queue
//   in_valid   in_data valid this cycle
//   in_ready   FIFO can accept (registered count below depth)
//   tx         serial line, registered, idle high
//   busy       serialiser active or bytes still queued
//   fifo_count bytes queued, 0..DEPTH
//   overflow   sticky: a byte was offered while in_ready was low
module uart_tx_buffered #(
  parameter int CLOCKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int CW    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0]              CLK_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL     = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state, state_next;
  logic [CW-1:0]              clk_cnt, clk_cnt_next;
  logic [2:0]                 bit_cnt, bit_cnt_next;
  logic [7:0]                 shift, shift_next;
  logic                       tx_next;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push, pop, bit_done;

  // in_ready comes from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign bit_done   = (clk_cnt == CLK_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    pop          = 1'b0;
    tx_next      = 1'b1;

    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          clk_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          shift_next   = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          // Chain straight into the next frame so back-to-back bytes leave
          // no idle gap on the line.
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is loaded from the level of the state being entered, so the line
    // changes on the same edge as the state and stays glitch-free.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DLOG  = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic [DLOG:0]    fifo_count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus the one frame currently on the line.
  logic [7:0] q [$];
  int         cyc = 0;
  int         free_at = 0;
  bit         fr_valid = 0;
  int         fr_start = 0;
  logic [7:0] fr_byte = 8'h00;
  bit         m_ovf = 0;

  function automatic void model_step(input logic v, input logic [7:0] d, input logic r);
    int size0;
    cyc++;
    if (r) begin
      q.delete();
      fr_valid = 0;
      free_at  = 0;
      m_ovf    = 0;
      return;
    end
    size0 = q.size();
    if (size0 != 0 && cyc >= free_at) begin
      fr_byte  = q.pop_front();
      fr_start = cyc;
      fr_valid = 1;
      free_at  = cyc + FRAME;
    end
    if (v) begin
      if (size0 < DEPTH) q.push_back(d);
      else m_ovf = 1;
    end
  endfunction

  function automatic bit in_frame();
    return fr_valid && (cyc - fr_start) < FRAME;
  endfunction

  function automatic logic exp_tx();
    int k;
    if (!in_frame()) return 1'b1;
    k = (cyc - fr_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fr_byte[k-1];
  endfunction

  function automatic logic exp_busy();
    return (q.size() != 0) || in_frame();
  endfunction

  function automatic logic [DLOG:0] exp_count();
    return (DLOG+1)'(q.size());
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx cyc=%0d got %b exp 1", cyc, tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got %b exp 0", cyc, busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc=%0d got %b exp 1", cyc, in_ready); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count cyc=%0d got %0d exp 0", cyc, fifo_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf cyc=%0d got %b exp 0", cyc, overflow); end
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int n;
    tick(1'b1, b, 1'b0);
    n = cyc;
    for (int i = 0; i < FRAME + 6; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL single_tx byte=%h cyc=%0d got %b exp %b", b, cyc, tx, exp_tx()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy()); end
      checks++; if (fifo_count !== exp_count()) begin errors++; $display("FAIL single_count cyc=%0d got %0d exp %0d", cyc, fifo_count, exp_count()); end
      if (cyc == n + 1) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_latency cyc=%0d got %b exp 0", cyc, tx); end
      end
      if (cyc == n + FRAME + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end cyc=%0d got %b exp 0", cyc, busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, bytes[i], 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
    for (int i = 0; i < 3 * FRAME + 5; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL b2b_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy()); end
      checks++; if (fifo_count !== exp_count()) begin errors++; $display("FAIL b2b_count cyc=%0d got %0d exp %0d", cyc, fifo_count, exp_count()); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8 + 6 * FRAME; i++) begin
      if (i < 8) tick(1'b1, 8'h10 + 8'(i), 1'b0);
      else tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL ovf_ready cyc=%0d got %b exp %b", cyc, in_ready, q.size() < DEPTH); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag cyc=%0d got %b exp %b", cyc, overflow, m_ovf); end
      checks++; if (fifo_count !== exp_count()) begin errors++; $display("FAIL ovf_count cyc=%0d got %0d exp %0d", cyc, fifo_count, exp_count()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL ovf_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy()); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 8'h00, 1'b1);
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i == 0) tick(1'b1, 8'($urandom), 1'b0);
        else tick(1'b0, 8'h00, 1'b0);
        checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL wrap_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
        checks++; if (fifo_count !== exp_count()) begin errors++; $display("FAIL wrap_count cyc=%0d got %0d exp %0d", cyc, fifo_count, exp_count()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf cyc=%0d got %b exp 0", cyc, overflow); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL wrap_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'($urandom), 1'b0);
    tick(1'b1, 8'($urandom), 1'b0);
    waited = 0;
    // Stop part-way through data bit 3 (fifth bit slot of the frame).
    while ((cyc - fr_start) != 4 * CPB + 1 && waited < 100) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL mid_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
      waited++;
    end
    checks++; if (waited >= 100) begin errors++; $display("FAIL mid_reach_bit3 got timeout exp reached"); end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_queued got %0d exp 2", fifo_count); end
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b exp 1", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_after_tx cyc=%0d got %b exp 1", cyc, tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy cyc=%0d got %b exp 0", cyc, busy); end
    end
  endtask

  task automatic test_random();
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 6) == 0, 8'($urandom), 1'b0);
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL rand_tx cyc=%0d got %b exp %b", cyc, tx, exp_tx()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rand_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy()); end
      checks++; if (fifo_count !== exp_count()) begin errors++; $display("FAIL rand_count cyc=%0d got %0d exp %0d", cyc, fifo_count, exp_count()); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, in_ready, q.size() < DEPTH); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc=%0d got %b exp %b", cyc, overflow, m_ovf); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
